id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage pipelined CPU.
- Captures decode-stage results at each clock edge and presents them to the EX stage: PC, instruction, register-file read data, the 32-bit extended immediate from the immediate extender, register specifiers and the control bundle.
- Implements hold (EX frozen by a multi-cycle unit), bubble insertion (load-use hazard) and flush (branch/exception).
- Keeps a saturating count of inserted bubbles for performance analysis.

---
 rtl/id_ex_pipe_reg.sv | 158 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold, bubble and flush, plus a saturating bubble counter.
// Optional macro ID_EX_WB_REFRESH_EN: refresh held operands from write-back during hold.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] pc_d,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [DATA_W-1:0] rs_data_d,
  input  logic [DATA_W-1:0] rt_data_d,
  input  logic [DATA_W-1:0] ext_d,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic [4:0]        rd_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              valid_e,
  output logic [DATA_W-1:0] pc_e,
  output logic [DATA_W-1:0] instr_e,
  output logic [DATA_W-1:0] rs_data_e,
  output logic [DATA_W-1:0] rt_data_e,
  output logic [DATA_W-1:0] ext_e,
  output logic [4:0]        rs_e,
  output logic [4:0]        rt_e,
  output logic [4:0]        rd_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] ext;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } stage_t;

  typedef enum logic [1:0] {
    ActLoad,
    ActBubble,
    ActHold,
    ActFlush
  } action_e;

  action_e          action;
  stage_t           stage_q, stage_d, id_stage;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             cnt_full;

  always_comb begin
    id_stage         = '0;
    id_stage.valid   = valid_d;
    id_stage.pc      = pc_d;
    id_stage.instr   = instr_d;
    id_stage.rs_data = rs_data_d;
    id_stage.rt_data = rt_data_d;
    id_stage.ext     = ext_d;
    id_stage.rs      = rs_d;
    id_stage.rt      = rt_d;
    id_stage.rd      = rd_d;
    id_stage.ctrl    = ctrl_d;
  end

  // Flush beats hold so a killed instruction cannot linger; hold masks a concurrent bubble.
  always_comb begin
    action = ActLoad;
    if (flush) begin
      action = ActFlush;
    end else if (hold) begin
      action = ActHold;
    end else if (bubble) begin
      action = ActBubble;
    end
  end

  assign cnt_full = (bubble_cnt_q == {CNT_W{1'b1}});

`ifdef ID_EX_WB_REFRESH_EN
  logic rs_hit, rt_hit;

  assign rs_hit = wb_we && (wb_addr != 5'd0) && (wb_addr == stage_q.rs);
  assign rt_hit = wb_we && (wb_addr != 5'd0) && (wb_addr == stage_q.rt);
`else
  logic unused_wb;

  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  // The NOP state is all-zero, which also clears ctrl so no downstream enable fires.
  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    unique case (action)
      ActFlush: begin
        stage_d = '0;
      end
      ActHold: begin
`ifdef ID_EX_WB_REFRESH_EN
        if (rs_hit) begin
          stage_d.rs_data = wb_data;
        end
        if (rt_hit) begin
          stage_d.rt_data = wb_data;
        end
`endif
      end
      ActBubble: begin
        stage_d = '0;
        if (!cnt_full) begin
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
      end
      ActLoad: begin
        stage_d = id_stage;
      end
      default: begin
        stage_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_e    = stage_q.valid;
  assign pc_e       = stage_q.pc;
  assign instr_e    = stage_q.instr;
  assign rs_data_e  = stage_q.rs_data;
  assign rt_data_e  = stage_q.rt_data;
  assign ext_e      = stage_q.ext;
  assign rs_e       = stage_q.rs;
  assign rt_e       = stage_q.rt;
  assign rd_e       = stage_q.rd;
  assign ctrl_e     = stage_q.ctrl;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed plan steps followed by random control traffic.
// Two instances share stimulus; the second uses CNT_W=4 to reach counter saturation quickly.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, hold, bubble, flush, valid_d, wb_we;
  logic [31:0] pc_d, instr_d, rs_data_d, rt_data_d, ext_d, wb_data;
  logic [4:0]  rs_d, rt_d, rd_d, wb_addr;
  logic [15:0] ctrl_d;

  logic        valid_e, valid_e4;
  logic [31:0] pc_e, instr_e, rs_data_e, rt_data_e, ext_e;
  logic [31:0] pc_e4, instr_e4, rs_data_e4, rt_data_e4, ext_e4;
  logic [4:0]  rs_e, rt_e, rd_e, rs_e4, rt_e4, rd_e4;
  logic [15:0] ctrl_e, ctrl_e4, bubble_cnt;
  logic [3:0]  bubble_cnt4;

  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, rs_data, rt_data, ext;
    logic [4:0]  rs, rt, rd;
    logic [15:0] ctrl;
    int          cnt16;
    int          cnt4;
  } exp_t;

  exp_t model;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
    .valid_d(valid_d), .pc_d(pc_d), .instr_d(instr_d), .rs_data_d(rs_data_d),
    .rt_data_d(rt_data_d), .ext_d(ext_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .ctrl_d(ctrl_d), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .valid_e(valid_e), .pc_e(pc_e), .instr_e(instr_e), .rs_data_e(rs_data_e),
    .rt_data_e(rt_data_e), .ext_e(ext_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .ctrl_e(ctrl_e), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
    .valid_d(valid_d), .pc_d(pc_d), .instr_d(instr_d), .rs_data_d(rs_data_d),
    .rt_data_d(rt_data_d), .ext_d(ext_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .ctrl_d(ctrl_d), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .valid_e(valid_e4), .pc_e(pc_e4), .instr_e(instr_e4), .rs_data_e(rs_data_e4),
    .rt_data_e(rt_data_e4), .ext_e(ext_e4), .rs_e(rs_e4), .rt_e(rt_e4), .rd_e(rd_e4),
    .ctrl_e(ctrl_e4), .bubble_cnt(bubble_cnt4)
  );

  // Reference: what EX should hold after one edge, from the priority rules directly.
  function automatic exp_t model_next(exp_t cur);
    exp_t nxt;
    exp_t nop;
    nop = '{valid: 1'b0, pc: 32'd0, instr: 32'd0, rs_data: 32'd0, rt_data: 32'd0,
            ext: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, ctrl: 16'd0, cnt16: 0, cnt4: 0};
    nxt = cur;
    if (reset) begin
      nxt = nop;
    end else if (flush) begin
      nxt = nop;
      nxt.cnt16 = cur.cnt16;
      nxt.cnt4  = cur.cnt4;
    end else if (hold) begin
`ifdef ID_EX_WB_REFRESH_EN
      if (wb_we && wb_addr != 0 && wb_addr == cur.rs) nxt.rs_data = wb_data;
      if (wb_we && wb_addr != 0 && wb_addr == cur.rt) nxt.rt_data = wb_data;
`endif
    end else if (bubble) begin
      nxt = nop;
      nxt.cnt16 = (cur.cnt16 < 65535) ? cur.cnt16 + 1 : cur.cnt16;
      nxt.cnt4  = (cur.cnt4 < 15) ? cur.cnt4 + 1 : cur.cnt4;
    end else begin
      nxt = '{valid: valid_d, pc: pc_d, instr: instr_d, rs_data: rs_data_d,
              rt_data: rt_data_d, ext: ext_d, rs: rs_d, rt: rt_d, rd: rd_d,
              ctrl: ctrl_d, cnt16: cur.cnt16, cnt4: cur.cnt4};
    end
    return nxt;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push the expected state for the current inputs, then let the edge happen.
  task automatic step();
    model = model_next(model);
    exp_q.push_back(model);
    @(posedge clk);
    #2;
  endtask

  task automatic set_ctrl(input logic r, input logic f, input logic h, input logic b);
    reset = r; flush = f; hold = h; bubble = b;
  endtask

  task automatic rand_data();
    valid_d   = 1'($urandom);
    pc_d      = $urandom;
    instr_d   = $urandom;
    rs_data_d = $urandom;
    rt_data_d = $urandom;
    ext_d     = $urandom;
    rs_d      = 5'($urandom_range(0, 7));
    rt_d      = 5'($urandom_range(0, 7));
    rd_d      = 5'($urandom);
    ctrl_d    = 16'($urandom);
    wb_we     = 1'($urandom);
    wb_addr   = 5'($urandom_range(0, 7));
    wb_data   = $urandom;
  endtask

  // Monitor: outputs are registered, so compare shortly after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_e", 64'(valid_e), 64'(e.valid));
        chk("pc_e", 64'(pc_e), 64'(e.pc));
        chk("instr_e", 64'(instr_e), 64'(e.instr));
        chk("rs_data_e", 64'(rs_data_e), 64'(e.rs_data));
        chk("rt_data_e", 64'(rt_data_e), 64'(e.rt_data));
        chk("ext_e", 64'(ext_e), 64'(e.ext));
        chk("rs_e", 64'(rs_e), 64'(e.rs));
        chk("rt_e", 64'(rt_e), 64'(e.rt));
        chk("rd_e", 64'(rd_e), 64'(e.rd));
        chk("ctrl_e", 64'(ctrl_e), 64'(e.ctrl));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt16));
        chk("cnt4.valid_e", 64'(valid_e4), 64'(e.valid));
        chk("cnt4.state", {pc_e4, instr_e4 ^ rs_data_e4},
            {e.pc, e.instr ^ e.rs_data});
        chk("cnt4.fields", {rt_data_e4, ext_e4}, {e.rt_data, e.ext});
        chk("cnt4.spec_ctrl", 64'({rs_e4, rt_e4, rd_e4, ctrl_e4}),
            64'({e.rs, e.rt, e.rd, e.ctrl}));
        chk("cnt4.bubble_cnt", 64'(bubble_cnt4), 64'(e.cnt4));
      end
    end
  end

  initial begin
    int wait_cycles;
    model = '{valid: 1'b0, pc: 32'd0, instr: 32'd0, rs_data: 32'd0, rt_data: 32'd0,
              ext: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, ctrl: 16'd0, cnt16: 0, cnt4: 0};
    // Reset held two cycles with every data input nonzero.
    valid_d = 1'b1; pc_d = 32'h1111_1111; instr_d = 32'h2222_2222;
    rs_data_d = 32'h3333_3333; rt_data_d = 32'h4444_4444; ext_d = 32'h5555_5555;
    rs_d = 5'd1; rt_d = 5'd2; rd_d = 5'd3; ctrl_d = 16'hFFFF;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    set_ctrl(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    step();
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    pc_d = 32'h0000_3000; ext_d = 32'hFFFF_8000;
    step();
    // Hold across changing ID contents.
    instr_d = 32'h8C22_0004;
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_d = 32'hA000_0000 + 32'(i);
      step();
    end
    hold = 1'b0;
    instr_d = 32'h0123_4567;
    step();
    // Three separate bubbles, then hold+bubble.
    for (int i = 0; i < 3; i++) begin
      bubble = 1'b1;
      step();
      bubble = 1'b0;
      pc_d = 32'h100 + 32'(i);
      step();
    end
    hold = 1'b1; bubble = 1'b1;
    step();
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    // Flush together with hold while EX is valid.
    set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    // Write-back during hold, matching and zero destination.
    rs_d = 5'd5; rt_d = 5'd6; rs_data_d = 32'hAAAA_AAAA; rt_data_d = 32'hBBBB_BBBB;
    step();
    hold = 1'b1; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
    step();
    wb_addr = 5'd0; wb_data = 32'h9999_9999;
    step();
    rs_d = 5'd0; rt_d = 5'd0;
    hold = 1'b0; wb_we = 1'b0;
    step();
    hold = 1'b1; wb_we = 1'b1; wb_addr = 5'd0;
    step();
    hold = 1'b0; wb_we = 1'b0;
    // Twenty bubbles saturate the 4-bit counter.
    bubble = 1'b1;
    for (int i = 0; i < 20; i++) step();
    bubble = 1'b0;
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      set_ctrl($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 30);
      step();
    end
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
